// File: rtl/filter_pkg.sv
// Shared widths, coefficient constants and FSM encoding for the one-pole
// recursive lowpass voice sequencer and its coefficient helper.
package filter_pkg;

    localparam int SAMPLE_W = 18;
    localparam int COEF_W   = 18;
    localparam int DELAY_W  = 36;
    localparam int ACC_W    = 37;
    localparam int PROD_W   = SAMPLE_W + COEF_W;

    localparam logic [DELAY_W-1:0] DELAY_MAX = 36'h7FFFFFFFF;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        MUL,
        WRITE
    } seq_state_t;

    // Doubles the product sum (restores the Q0.17 x Q0.17 gain) and clamps it
    // into the signed product range instead of letting it wrap.
    function automatic logic signed [PROD_W-1:0] gain_saturate(
        input logic signed [ACC_W-1:0] sum
    );
        logic signed [ACC_W:0] dbl;
        logic [2:0]            top;
        dbl = {sum, 1'b0};
        top = dbl[ACC_W:PROD_W-1];
        if (top == 3'b000 || top == 3'b111) begin
            return dbl[PROD_W-1:0];
        end else if (!dbl[ACC_W]) begin
            return {1'b0, {(PROD_W-1){1'b1}}};
        end else begin
            return {1'b1, {(PROD_W-1){1'b0}}};
        end
    endfunction

endpackage

// File: rtl/onepole_coef.sv
// Maps a signed Q0.35 delay value to the one-pole coefficient pair
// {a0, b1}; negative delays are treated as zero. Purely combinational.
module onepole_coef
    import filter_pkg::*;
(
    input  logic signed [DELAY_W-1:0] delay_i,
    output logic signed [COEF_W-1:0]  a0_o,
    output logic signed [COEF_W-1:0]  b1_o
);

    logic [DELAY_W-1:0] clamped;
    logic [DELAY_W-1:0] complement;

    assign clamped    = delay_i[DELAY_W-1] ? '0 : delay_i;
    assign complement = DELAY_MAX - clamped;

    // Both operands are non-negative here, so the top bits equal an arithmetic shift.
    assign b1_o = clamped[DELAY_W-1 -: COEF_W];
    assign a0_o = complement[DELAY_W-1 -: COEF_W];

endmodule

// File: rtl/recursive_filter_sequencer.sv
// Time-multiplexed one-pole lowpass: once per sample tick, walks every voice
// through FETCH/MUL/WRITE, updating its stored output and emitting one sample.
module recursive_filter_sequencer
    import filter_pkg::*;
#(
    parameter int VOICES = 8,
    parameter int IDX_W  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_tick,
    output logic [IDX_W-1:0]           sel_voice,
    input  logic signed [SAMPLE_W-1:0] data_in,
    input  logic signed [DELAY_W-1:0]  delay,
    input  logic                       clr_req,
    input  logic [IDX_W-1:0]           clr_voice,
    output logic                       out_valid,
    output logic [IDX_W-1:0]           out_voice,
    output logic signed [SAMPLE_W-1:0] out_data,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    seq_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ld_fetch;
    logic             ld_mul;
    logic             wr_en;

    logic signed [SAMPLE_W-1:0] data_q;
    logic signed [DELAY_W-1:0]  delay_q;
    logic signed [SAMPLE_W-1:0] prev_q;
    logic signed [PROD_W-1:0]   p0_q;
    logic signed [PROD_W-1:0]   p1_q;

    logic                       out_valid_q;
    logic [IDX_W-1:0]           out_voice_q;
    logic signed [SAMPLE_W-1:0] out_data_q;
    logic                       done_q;
    logic                       overrun_q;

    logic signed [COEF_W-1:0]   a0;
    logic signed [COEF_W-1:0]   b1;
    logic signed [ACC_W-1:0]    sum;
    logic signed [PROD_W-1:0]   sat;
    logic signed [SAMPLE_W-1:0] y;

    logic signed [SAMPLE_W-1:0] state_rd [VOICES];

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ld_fetch = 1'b0;
        ld_mul   = 1'b0;
        wr_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                ld_fetch = 1'b1;
                state_d  = MUL;
            end
            MUL: begin
                ld_mul  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                wr_en = 1'b1;
                // idx returns to 0 on the way out so sel_voice reads 0 while idle.
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arithmetic pipeline
    // ------------------------------------------------------------------
    onepole_coef u_coef (
        .delay_i (delay_q),
        .a0_o    (a0),
        .b1_o    (b1)
    );

    assign sum = $signed({p0_q[PROD_W-1], p0_q}) + $signed({p1_q[PROD_W-1], p1_q});
    assign sat = gain_saturate(sum);
    assign y   = sat[PROD_W-1 -: SAMPLE_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            delay_q <= '0;
            prev_q  <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
        end else begin
            // prev is captured here, so a later clear of this voice cannot disturb the in-flight result.
            if (ld_fetch) begin
                data_q  <= data_in;
                delay_q <= delay;
                prev_q  <= state_rd[idx_q];
            end
            if (ld_mul) begin
                p0_q <= PROD_W'(data_q) * PROD_W'(a0);
                p1_q <= PROD_W'(prev_q) * PROD_W'(b1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-voice filter state: one write port, clear port has priority
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < VOICES; gi++) begin : g_state
        logic signed [SAMPLE_W-1:0] cell_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                cell_q <= '0;
            end else if (clr_req && (clr_voice == IDX_W'(gi))) begin
                cell_q <= '0;
            end else if (wr_en && (idx_q == IDX_W'(gi))) begin
                cell_q <= y;
            end
        end

        assign state_rd[gi] = cell_q;
    end

    // ------------------------------------------------------------------
    // Output and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_voice_q <= '0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            out_valid_q <= wr_en;
            done_q      <= wr_en && (idx_q == LAST_IDX);
            if (wr_en) begin
                out_voice_q <= idx_q;
                out_data_q  <= y;
            end
            if (sample_tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign sel_voice = idx_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_voice = out_voice_q;
    assign out_data  = out_data_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule
